// File: rtl/rv32i_pkg.sv
// RV32I opcode constants and pipeline-control state type shared by the control slice.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_IW    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/rv32i_pipe_ctrl_if.sv
// Instruction/memory status in, stage enables and bubble selects out; slave side is the controller.
interface rv32i_pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      id_iw;
  logic [31:0]      ex_iw;
  logic             jump_req;
  logic             mem_req;
  logic             mem_ready;
  logic             resume;
  logic             if_stall;
  logic             id_stall;
  logic             ex_stall;
  logic             id_bubble;
  logic             if_flush;
  logic             jump_allow;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_iw, ex_iw, jump_req, mem_req, mem_ready, resume,
    input  if_stall, id_stall, ex_stall, id_bubble, if_flush, jump_allow, halted, state, stall_cnt
  );

  modport slave (
    input  id_iw, ex_iw, jump_req, mem_req, mem_ready, resume,
    output if_stall, id_stall, ex_stall, id_bubble, if_flush, jump_allow, halted, state, stall_cnt
  );
endinterface

// File: rtl/rv32i_hazard_detect.sv
// Load-use detector: load in EX writing a register the ID instruction reads.
// Purely combinational, zero latency, no backpressure of its own.
module rv32i_hazard_detect
  import rv32i_pkg::*;
(
  input  logic [31:0] id_iw,
  input  logic [31:0] ex_iw,
  output logic        lu_hazard
);

  logic [6:0] id_op;
  logic [4:0] ex_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       unused_bits;

  assign id_op = id_iw[6:0];
  assign ex_rd = ex_iw[11:7];

  assign uses_rs1 = !(id_op inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2 = id_op inside {OP_OP, OP_STORE, OP_BRANCH};

  assign lu_hazard = (ex_iw[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (id_iw[19:15] == ex_rd)) ||
                      (uses_rs2 && (id_iw[24:20] == ex_rd)));

  assign unused_bits = ^{ex_iw[31:12], id_iw[31:25], id_iw[14:7]};

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline stall/flush/halt sequencer; outputs combinational from state + inputs, state registered.
// Priority: mem wait > HALT > load-use > jump flush > normal; mem wait freezes every stage.
module rv32i_pipe_ctrl
  import rv32i_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic               clk,
  input logic               reset,
  rv32i_pipe_ctrl_if.slave  bus
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
    $error("rv32i_pipe_ctrl: FLUSH_CYCLES must be in 1..3");
  end

  pipe_state_t      state_q, state_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             resume_pend_q, resume_pend_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             lu_hazard;
  logic             mem_wait;
  logic             is_ebreak;
  logic             if_stall, id_stall, ex_stall, id_bubble, if_flush, jump_allow, halted;

  rv32i_hazard_detect u_hazard (
    .id_iw     (bus.id_iw),
    .ex_iw     (bus.ex_iw),
    .lu_hazard (lu_hazard)
  );

  assign mem_wait  = bus.mem_req && !bus.mem_ready;
  assign is_ebreak = (bus.id_iw == EBREAK_IW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 2'd0;
      resume_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      resume_pend_q <= resume_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    resume_pend_d = resume_pend_q;
    case (state_q)
      ST_RUN: begin
        if (!mem_wait && !lu_hazard) begin
          if (is_ebreak) begin
            state_d = ST_HALT;
          end else if (bus.jump_req && FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 2'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        if (!mem_wait && !lu_hazard) begin
          flush_cnt_d = flush_cnt_q - 2'd1;
          if (flush_cnt_q == 2'd1) state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        // A resume pulse that lands in a memory wait is remembered until the wait clears.
        if (mem_wait) begin
          resume_pend_d = resume_pend_q | bus.resume;
        end else if (bus.resume || resume_pend_q) begin
          state_d       = ST_RUN;
          resume_pend_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    id_bubble  = 1'b0;
    if_flush   = 1'b0;
    jump_allow = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      jump_allow = 1'b1;
    end else begin
      halted = (state_q == ST_HALT);
      if (mem_wait) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_stall = 1'b1;
      end else if (state_q == ST_HALT || lu_hazard) begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        id_bubble = 1'b1;
      end else if (state_q == ST_FLUSH) begin
        if_flush = 1'b1;
      end else begin
        jump_allow = 1'b1;
        if_flush   = bus.jump_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if ((if_stall || ex_stall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.if_stall   = if_stall;
  assign bus.id_stall   = id_stall;
  assign bus.ex_stall   = ex_stall;
  assign bus.id_bubble  = id_bubble;
  assign bus.if_flush   = if_flush;
  assign bus.jump_allow = jump_allow;
  assign bus.halted     = halted;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed and random stimulus for rv32i_pipe_ctrl against a cycle-level reference model.
module tb_rv32i_pipe_ctrl;

  localparam int FC      = 2;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] LW5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW0   = {12'd0, 5'd5, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD65 = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI5  = {20'h00028, 5'd5, 7'b0110111};
  localparam logic [31:0] JALR5 = {12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv32i_pipe_ctrl_if #(.CNT_W(CW)) bus ();
  rv32i_pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: halted flag, remaining squash cycles, remembered resume, stall total.
  bit m_halt;
  bit m_pend;
  int m_flush_left;
  int m_cnt;

  logic [6:0] obs;
  assign obs = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.id_bubble,
                bus.if_flush, bus.jump_allow, bus.halted};

  logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                          7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_lu(input logic [31:0] id, input logic [31:0] ex);
    logic [4:0] rd;
    bit r1;
    bit r2;
    rd = ex[11:7];
    r1 = 1'b1;
    r2 = 1'b0;
    if (ex[6:0] != 7'b0000011 || rd == 5'd0) return 1'b0;
    case (id[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: r1 = 1'b0;
      7'b0110011, 7'b0100011, 7'b1100011: r2 = 1'b1;
      default: ;
    endcase
    return (r1 && id[19:15] == rd) || (r2 && id[24:20] == rd);
  endfunction

  task automatic model_out(output logic [6:0] o, output bit any);
    bit mw;
    bit lu;
    mw = bus.mem_req && !bus.mem_ready;
    lu = ref_lu(bus.id_iw, bus.ex_iw);
    o = 7'b0;
    o[0] = m_halt;
    if (mw)                    o[6:4] = 3'b111;
    else if (m_halt || lu)     begin o[6:5] = 2'b11; o[3] = 1'b1; end
    else if (m_flush_left > 0) o[2] = 1'b1;
    else                       begin o[1] = 1'b1; o[2] = bus.jump_req; end
    any = o[6] | o[4];
  endtask

  task automatic check_model();
    logic [6:0] o;
    bit any;
    int st;
    if (!reset) begin
      chk("rst_outs", 32'(obs), 32'(7'b0000010));
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    end else begin
      model_out(o, any);
      st = m_halt ? 2 : (m_flush_left > 0 ? 1 : 0);
      chk("outs", 32'(obs), 32'(o));
      chk("state", 32'(bus.state), 32'(st));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    end
  endtask

  task automatic model_reset();
    m_halt = 1'b0;
    m_pend = 1'b0;
    m_flush_left = 0;
    m_cnt = 0;
  endtask

  task automatic model_tick();
    logic [6:0] o;
    bit any;
    if (!reset) begin
      model_reset();
      return;
    end
    model_out(o, any);
    if (any && m_cnt < CNT_MAX) m_cnt++;
    if (bus.mem_req && !bus.mem_ready) begin
      if (m_halt && bus.resume) m_pend = 1'b1;
    end else if (m_halt) begin
      if (bus.resume || m_pend) begin m_halt = 1'b0; m_pend = 1'b0; end
    end else if (ref_lu(bus.id_iw, bus.ex_iw)) begin
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (bus.id_iw == EBRK) begin
      m_halt = 1'b1;
    end else if (bus.jump_req) begin
      m_flush_left = FC - 1;
    end
  endtask

  task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                       input logic jr, input logic mq, input logic mr, input logic rs);
    @(negedge clk);
    bus.id_iw = id; bus.ex_iw = ex; bus.jump_req = jr;
    bus.mem_req = mq; bus.mem_ready = mr; bus.resume = rs;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  function automatic logic [31:0] rand_id();
    logic [31:0] iw;
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return EBRK;
    if (k == 1) return ECALL;
    iw = $urandom;
    iw[6:0]   = ops[$urandom_range(0, 8)];
    iw[19:15] = 5'($urandom_range(0, 3));
    iw[24:20] = 5'($urandom_range(0, 3));
    return iw;
  endfunction

  function automatic logic [31:0] rand_ex();
    logic [31:0] iw;
    iw = $urandom;
    iw[6:0]  = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'b0010011;
    iw[11:7] = 5'($urandom_range(0, 3));
    return iw;
  endfunction

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(rand_id(), rand_ex(), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      tick();
    end
  endtask

  initial begin
    model_reset();
    drive(NOP, LW5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #2 reset = 1'b1;

    // load-use: one stall cycle, then release; rd=x0 and LUI never stall
    drive(ADD65, LW5, 0, 0, 0, 0);
    chk("lu_stall", 32'({bus.if_stall, bus.id_stall, bus.id_bubble}), 32'h7);
    tick();
    drive(ADD65, NOP, 0, 0, 0, 0);
    chk("lu_release", 32'(bus.if_stall), 32'd0);
    tick();
    drive(ADD65, LW0, 0, 0, 0, 0);
    chk("lu_rd_x0", 32'(bus.if_stall), 32'd0);
    tick();
    drive(LUI5, LW5, 0, 0, 0, 0);
    chk("lu_lui", 32'(bus.id_bubble), 32'd0);
    tick();

    // jump with two squash cycles
    drive(NOP, NOP, 1, 0, 0, 0);
    chk("jmp_flush0", 32'(bus.if_flush), 32'd1);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("jmp_flush1", 32'({bus.if_flush, bus.jump_allow, bus.state}), 32'b1001);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("jmp_done", 32'({bus.if_flush, bus.state}), 32'd0);
    tick();

    // memory wait freezes FLUSH for three cycles
    drive(NOP, NOP, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(NOP, NOP, 0, 1, 0, 0);
      chk("mw_frozen", 32'({bus.ex_stall, bus.if_flush, bus.state}), 32'b1001);
      tick();
    end
    drive(NOP, NOP, 0, 1, 1, 0);
    chk("mw_resume_flush", 32'({bus.if_flush, bus.state}), 32'b101);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    tick();

    // load-use suppresses jump, which then flushes next cycle
    drive(JALR5, LW5, 1, 0, 0, 0);
    chk("lu_jmp_block", 32'({bus.jump_allow, bus.if_flush}), 32'd0);
    tick();
    drive(JALR5, NOP, 1, 0, 0, 0);
    chk("lu_jmp_flush", 32'(bus.if_flush), 32'd1);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    tick();

    // EBREAK halt, resume during a wait, then resume; ECALL never halts
    drive(EBRK, NOP, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(NOP, NOP, 0, 0, 0, 0);
      chk("halt_hold", 32'({bus.halted, bus.state}), 32'b110);
      tick();
    end
    drive(NOP, NOP, 0, 1, 0, 1);
    tick();
    drive(NOP, NOP, 0, 1, 0, 0);
    chk("halt_in_wait", 32'(bus.state), 32'd2);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("resumed", 32'(bus.state), 32'd0);
    tick();
    drive(ECALL, NOP, 0, 0, 0, 0);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("ecall_no_halt", 32'(bus.halted), 32'd0);
    tick();

    rand_cycles(400);

    // saturate the stall counter
    for (int i = 0; i < CNT_MAX + 8; i++) begin
      drive(NOP, NOP, 0, 1, 0, 0);
      tick();
    end
    drive(NOP, NOP, 0, 1, 0, 0);
    chk("cnt_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
    tick();

    // asynchronous reset in the middle of a HALT cycle
    drive(EBRK, NOP, 0, 0, 0, 0);
    tick();
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("pre_rst_halt", 32'(bus.halted), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_outs", 32'(obs), 32'(7'b0000010));
    chk("async_rst_state", 32'(bus.state), 32'd0);
    chk("async_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    rand_cycles(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
